max_stream_reducer: RTL and testbench

- Sequential front-end for the team's max-comparator datapath: accepts a stream of unsigned operands per frame over valid/ready and reduces each frame to its maximum value and the index of that value.
- Sits directly upstream of the downstream max-select/consumer logic.
- Internally reuses a combinational compare cell of the same greater-than/less-than form as the existing max partitions.
- Registers the running maximum so the downstream sees one registered result per frame.

---
 rtl/max_pkg.sv | 17 +
 rtl/max_cmp_cell.sv | 20 ++
 rtl/max_stream_reducer.sv | 120 ++++++++++++
 tb/tb_max_stream_reducer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/max_pkg.sv
// Shared types and defaults for the max stream reducer slice.
package max_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 8;
  localparam int unsigned DEFAULT_MAX_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_e;

  function automatic int unsigned idx_width(input int unsigned max_len);
    return $clog2(max_len);
  endfunction

endpackage

// File: rtl/max_cmp_cell.sv
// Combinational greater-than / less-than compare cell.
// MAX_STREAM_SIGNED_EN selects a two's-complement compare instead of unsigned.
module max_cmp_cell #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt
);

`ifdef MAX_STREAM_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
  assign lt = $signed(a) < $signed(b);
`else
  assign gt = a > b;
  assign lt = a < b;
`endif

endmodule

// File: rtl/max_stream_reducer.sv
// Reduces each valid/ready operand frame to its maximum, first index of that maximum and length.
// Signed operands when MAX_STREAM_SIGNED_EN is defined (handled in max_cmp_cell).
module max_stream_reducer
  import max_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
  parameter int unsigned IDX_W   = idx_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_trunc
);

  localparam logic [IDX_W:0] MAX_CNT = MAX_LEN[IDX_W:0];
  localparam logic [IDX_W:0] ONE     = {{IDX_W{1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  logic [WIDTH-1:0] acc_max_q, acc_max_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [IDX_W:0]   acc_cnt_q, acc_cnt_d;

  logic [WIDTH-1:0] out_max_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W:0]   out_count_q;
  logic             out_trunc_q;

  logic           accept, cmp_gt, unused_lt, take_new, close, trunc;
  logic [IDX_W:0] base_cnt;

  max_cmp_cell #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a  (in_data),
    .b  (acc_max_q),
    .gt (cmp_gt),
    .lt (unused_lt)
  );

  // The first word of a frame behaves like a compare against an empty frame: always taken.
  always_comb begin
    accept    = in_valid && in_ready_q;
    base_cnt  = (state_q == ACC) ? acc_cnt_q : '0;
    acc_cnt_d = base_cnt + ONE;
    take_new  = (state_q != ACC) || cmp_gt;
    acc_max_d = take_new ? in_data : acc_max_q;
    acc_idx_d = take_new ? base_cnt[IDX_W-1:0] : acc_idx_q;
    close     = in_last || (acc_cnt_d == MAX_CNT);
    trunc     = !in_last && (acc_cnt_d == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACC: if (accept) state_d = close ? OUT : ACC;
      OUT:       if (out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with the state register.
  always_comb begin
    in_ready_d  = (state_d != OUT);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_max_q   <= '0;
      acc_idx_q   <= '0;
      acc_cnt_q   <= '0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
    end else if (accept) begin
      acc_max_q <= acc_max_d;
      acc_idx_q <= acc_idx_d;
      acc_cnt_q <= acc_cnt_d;
      if (close) begin
        out_max_q   <= acc_max_d;
        out_idx_q   <= acc_idx_d;
        out_count_q <= acc_cnt_d;
        out_trunc_q <= trunc;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_max_stream_reducer.sv
// Directed scoreboard bench for max_stream_reducer (default parameters).
module tb_max_stream_reducer;

  localparam int W  = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_count;
  logic          out_trunc;

  typedef struct packed {
    logic [W-1:0]  m;
    logic [IW-1:0] i;
    logic [IW:0]   c;
    logic          t;
  } res_t;

  res_t exp_q[$];
  res_t mon_exp;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  max_stream_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] m, input logic [IW-1:0] i, input logic [IW:0] c,
                      input logic t);
    res_t r;
    r.m = m;
    r.i = i;
    r.c = c;
    r.t = t;
    exp_q.push_back(r);
  endtask

  // Entered and left at a negedge; returns once the current word has been taken.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    wait_accept(tag);
  endtask

  // Result checker: a transfer happens at the next posedge when valid and ready are both high.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_max", 32'(out_max), 32'(mon_exp.m));
        check("out_idx", 32'(out_idx), 32'(mon_exp.i));
        check("out_count", 32'(out_count), 32'(mon_exp.c));
        check("out_trunc", 32'(out_trunc), 32'(mon_exp.t));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_max", 32'(out_max), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_trunc", 32'(out_trunc), 32'd0);
    rst = 1'b0;

    // Tie on 9 keeps the first index
    push(8'd9, 4'd1, 5'd5, 1'b0);
    send(8'd3, 1'b0, "f1_w0");
    send(8'd9, 1'b0, "f1_w1");
    send(8'd4, 1'b0, "f1_w2");
    send(8'd9, 1'b0, "f1_w3");
    send(8'd1, 1'b1, "f1_w4");
    check("f1_valid_rise", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("f1_valid_fall", 32'(out_valid), 32'd0);

    push(8'hA5, 4'd0, 5'd1, 1'b0);
    send(8'hA5, 1'b1, "single");
    check("single_valid_rise", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("single_valid_fall", 32'(out_valid), 32'd0);

    // Force-closed frame, held under backpressure while a 17th word waits
    out_ready = 1'b0;
    push(8'd15, 4'd15, 5'd16, 1'b1);
    for (int i = 0; i < 16; i++) send(W'(i), 1'b0, "trunc_w");
    check("trunc_in_ready", 32'(in_ready), 32'd0);
    check("trunc_out_valid", 32'(out_valid), 32'd1);
    push(8'd16, 4'd0, 5'd1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd16;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_max", 32'(out_max), 32'd15);
      check("bp_out_count", 32'(out_count), 32'd16);
      check("bp_out_trunc", 32'(out_trunc), 32'd1);
    end
    out_ready = 1'b1;
    wait_accept("word17");
    @(negedge clk);

    // in_valid gap mid-frame
    push(8'd8, 4'd1, 5'd3, 1'b0);
    send(8'd2, 1'b0, "gap_w0");
    repeat (3) begin
      @(negedge clk);
      check("gap_no_valid", 32'(out_valid), 32'd0);
    end
    send(8'd8, 1'b0, "gap_w1");
    send(8'd1, 1'b1, "gap_w2");
    @(negedge clk);

    // All-equal, in_last on the MAX_LEN-th word
    push(8'd5, 4'd0, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) send(8'd5, i == 15, "eq_w");
    @(negedge clk);

    // Reset mid-frame discards the partial frame
    send(8'd1, 1'b0, "rst_w0");
    send(8'd2, 1'b0, "rst_w1");
    send(8'd3, 1'b0, "rst_w2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_valid", 32'(out_valid), 32'd0);
    end
    push(8'd7, 4'd0, 5'd1, 1'b0);
    send(8'd7, 1'b1, "after_rst");
    @(negedge clk);

    // Reset in OUT drops the unconsumed result
    out_ready = 1'b0;
    send(8'd4, 1'b1, "rst_out_w");
    check("rst_out_pending", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_dropped", 32'(out_valid), 32'd0);
    check("rst_out_max_clr", 32'(out_max), 32'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

`ifdef MAX_STREAM_SIGNED_EN
    push(8'h7F, 4'd0, 5'd3, 1'b0);
`else
    push(8'hFF, 4'd2, 5'd3, 1'b0);
`endif
    send(8'h7F, 1'b0, "sgn_w0");
    send(8'h80, 1'b0, "sgn_w1");
    send(8'hFF, 1'b1, "sgn_w2");

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
